// File: rtl/neuron_alu_engine.sv
// neuron_alu_engine
// Arithmetic responder for the neuron control engine. Executes multiply/
// accumulate (MUL_START), bias-add + activation (BIAS_ADD_START) and returns
// one-cycle ADD_DONE / ACT_DONE pulses. Signed fixed-point datapath, Q(WIDTH-
// FRAC_BITS).FRAC_BITS; the multiply is a WIDTH-cycle shift-add.
//
// Ports:
//   CLK, RST                    clock (rising edge), synchronous active-high reset
//   MUL_START                   one-cycle MAC command, samples A, B, ACC_MUX
//   MUL_VALUE_A_IN/_B_IN        signed operands
//   ACC_MUX                     0 = fresh sum, 1 = accumulate onto ACC
//   ADD_DONE                    one-cycle pulse, ACC updated on the same edge
//   BIAS_ADD_START, BIAS        one-cycle bias+activation command and bias value
//   ACT_DONE                    one-cycle pulse, VALUE_OUT updated on the same edge
//   VALUE_OUT                   activated output, held between ACT_DONE pulses
//   BUSY                        high while a command executes
//   PROTO_ERR                   sticky protocol-error flag, cleared by RST only
//   STATE_DBG, ACC_DBG          debug view of FSM state and accumulator
//
// Command handshake: a command is a single-cycle pulse that is accepted only
// when BUSY is low (state IDLE). BUSY drops on the same edge a done pulse is
// raised, so a new command driven during the done cycle is accepted. A command
// seen while BUSY is high, or both commands in the same IDLE cycle, sets
// PROTO_ERR; the busy-time command is discarded and MUL_START wins a tie.
module neuron_alu_engine #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 5,
  parameter int ACT_MODE  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MUL_START,
  input  logic [WIDTH-1:0] MUL_VALUE_A_IN,
  input  logic [WIDTH-1:0] MUL_VALUE_B_IN,
  input  logic             ACC_MUX,
  output logic             ADD_DONE,
  input  logic             BIAS_ADD_START,
  input  logic [WIDTH-1:0] BIAS,
  output logic             ACT_DONE,
  output logic [WIDTH-1:0] VALUE_OUT,
  output logic             BUSY,
  output logic             PROTO_ERR,
  output logic [2:0]       STATE_DBG,
  output logic [WIDTH-1:0] ACC_DBG
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADD  = 3'd2,
    S_BIAS = 3'd3,
    S_ACT  = 3'd4
  } state_t;

  localparam int PW = 2*WIDTH + 2;           // product register width
  localparam int CW = $clog2(WIDTH + 1);     // step counter width

  // Saturation bounds at the wide (PW+1) sum width.
  localparam logic signed [PW:0] MAX_W = {{(PW+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW:0] MIN_W = {{(PW+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};

  // +1.0 and -1.0 in the fixed-point format (assumes FRAC_BITS <= WIDTH-2).
  localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-1-FRAC_BITS){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;

  state_t                  state;
  logic signed [WIDTH-1:0] acc;
  logic [WIDTH-1:0]        value_out;
  logic                    add_done_q;
  logic                    act_done_q;
  logic                    busy_q;
  logic                    proto_err_q;
  logic                    acc_mux_q;
  logic                    sign_q;
  logic [PW-1:0]           mcand;
  logic [WIDTH:0]          mplr;
  logic [PW-1:0]           prod;
  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        bias_q;

  // Magnitude with one extra bit so that -2^(WIDTH-1) maps to +2^(WIDTH-1).
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -ext : ext;
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [PW:0] v);
    if (v > MAX_W)      return MAX_W[WIDTH-1:0];
    else if (v < MIN_W) return MIN_W[WIDTH-1:0];
    else                return v[WIDTH-1:0];
  endfunction

  logic [WIDTH:0]          mag_a;
  logic [WIDTH:0]          mag_b;
  logic signed [PW-1:0]    prod_s;
  logic signed [PW-1:0]    prod_sh;
  logic signed [PW:0]      add_sum;
  logic signed [PW:0]      bias_sum;
  logic [WIDTH-1:0]        act_val;

  always_comb begin
    mag_a   = mag(MUL_VALUE_A_IN);
    mag_b   = mag(MUL_VALUE_B_IN);
    prod_s  = sign_q ? -$signed(prod) : $signed(prod);
    // Arithmetic shift gives floor rounding for negative products.
    prod_sh = prod_s >>> FRAC_BITS;
    add_sum = $signed({prod_sh[PW-1], prod_sh}) +
              (acc_mux_q ? $signed({{(PW+1-WIDTH){acc[WIDTH-1]}}, acc}) : '0);
    bias_sum = $signed({{(PW+1-WIDTH){acc[WIDTH-1]}}, acc}) +
               $signed({{(PW+1-WIDTH){bias_q[WIDTH-1]}}, bias_q});
    act_val = acc;
    if (ACT_MODE == 0) begin
      if (acc[WIDTH-1]) act_val = '0;
    end else begin
      if (acc > ONE)          act_val = ONE;
      else if (acc < NEG_ONE) act_val = NEG_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      acc         <= '0;
      value_out   <= '0;
      add_done_q  <= 1'b0;
      act_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
      acc_mux_q   <= 1'b0;
      sign_q      <= 1'b0;
      mcand       <= '0;
      mplr        <= '0;
      prod        <= '0;
      cnt         <= '0;
      bias_q      <= '0;
    end else begin
      add_done_q <= 1'b0;
      act_done_q <= 1'b0;
      if (state != S_IDLE && (MUL_START || BIAS_ADD_START))
        proto_err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (MUL_START) begin
            acc_mux_q <= ACC_MUX;
            sign_q    <= MUL_VALUE_A_IN[WIDTH-1] ^ MUL_VALUE_B_IN[WIDTH-1];
            mcand     <= {{(PW-WIDTH-1){1'b0}}, mag_a};
            mplr      <= mag_b;
            prod      <= '0;
            cnt       <= '0;
            state     <= S_MUL;
            busy_q    <= 1'b1;
            if (BIAS_ADD_START) proto_err_q <= 1'b1;
          end else if (BIAS_ADD_START) begin
            bias_q <= BIAS;
            state  <= S_BIAS;
            busy_q <= 1'b1;
          end
        end
        S_MUL: begin
          if (mplr[0]) prod <= prod + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_ADD;
        end
        S_ADD: begin
          acc        <= sat(add_sum);
          add_done_q <= 1'b1;
          state      <= S_IDLE;
          busy_q     <= 1'b0;
        end
        S_BIAS: begin
          acc   <= sat(bias_sum);
          state <= S_ACT;
        end
        S_ACT: begin
          value_out  <= act_val;
          act_done_q <= 1'b1;
          state      <= S_IDLE;
          busy_q     <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign ADD_DONE  = add_done_q;
  assign ACT_DONE  = act_done_q;
  assign VALUE_OUT = value_out;
  assign BUSY      = busy_q;
  assign PROTO_ERR = proto_err_q;
  assign STATE_DBG = state;
  assign ACC_DBG   = acc;

endmodule

// File: tb/tb_neuron_alu_engine.sv
// tb_neuron_alu_engine
// Drives two engines (ReLU and hard-tanh builds) from the same command stream
// and compares accumulator, output value, done timing and flags against an
// integer-arithmetic reference model.
module tb_neuron_alu_engine;

  localparam int W = 8;
  localparam int F = 5;
  localparam int MAXV = (1 << (W-1)) - 1;
  localparam int MINV = -(1 << (W-1));
  localparam int ONEV = 1 << F;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         mul_start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         acc_mux;
  logic         bias_start;
  logic [W-1:0] bias_in;

  logic         add_done_r, act_done_r, busy_r, proto_r;
  logic [W-1:0] vout_r, acc_dbg_r;
  logic [2:0]   state_r;
  logic         add_done_t, act_done_t, busy_t, proto_t;
  logic [W-1:0] vout_t, acc_dbg_t;
  logic [2:0]   state_t_dbg;

  neuron_alu_engine #(.WIDTH(W), .FRAC_BITS(F), .ACT_MODE(0)) u_dut_relu (
    .CLK(clk), .RST(rst), .MUL_START(mul_start),
    .MUL_VALUE_A_IN(a_in), .MUL_VALUE_B_IN(b_in), .ACC_MUX(acc_mux),
    .ADD_DONE(add_done_r), .BIAS_ADD_START(bias_start), .BIAS(bias_in),
    .ACT_DONE(act_done_r), .VALUE_OUT(vout_r), .BUSY(busy_r),
    .PROTO_ERR(proto_r), .STATE_DBG(state_r), .ACC_DBG(acc_dbg_r)
  );

  neuron_alu_engine #(.WIDTH(W), .FRAC_BITS(F), .ACT_MODE(1)) u_dut_tanh (
    .CLK(clk), .RST(rst), .MUL_START(mul_start),
    .MUL_VALUE_A_IN(a_in), .MUL_VALUE_B_IN(b_in), .ACC_MUX(acc_mux),
    .ADD_DONE(add_done_t), .BIAS_ADD_START(bias_start), .BIAS(bias_in),
    .ACT_DONE(act_done_t), .VALUE_OUT(vout_t), .BUSY(busy_t),
    .PROTO_ERR(proto_t), .STATE_DBG(state_t_dbg), .ACC_DBG(acc_dbg_t)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int m_acc = 0;
  int m_vr  = 0;
  int m_vt  = 0;
  int add_pulses = 0;
  int act_pulses = 0;

  always @(negedge clk) begin
    if (add_done_r) add_pulses <= add_pulses + 1;
    if (act_done_r) act_pulses <= act_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [W-1:0] to_w(input int v);
    return v[W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge with the engine idle (or in a done cycle).
  task automatic do_mac(input logic [W-1:0] a, input logic [W-1:0] b, input logic mux,
                        input bit inj, input bit both);
    int cyc;
    logic [W-1:0] e;
    m_acc = clampi((mux ? m_acc : 0) + ((sx(a) * sx(b)) >>> F), MINV, MAXV);
    exp_q.push_back(to_w(m_acc));
    a_in = a; b_in = b; acc_mux = mux; mul_start = 1'b1;
    bias_start = both; bias_in = 8'h11;
    @(negedge clk);
    mul_start = 1'b0; bias_start = 1'b0;
    check("mac_busy", busy_r, 1);
    cyc = 0;
    while (!add_done_r && cyc < 40) begin
      if (inj && cyc == 3) begin
        mul_start = 1'b1; a_in = ~a; b_in = 8'h7f; acc_mux = ~mux;
      end else mul_start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    mul_start = 1'b0;
    check("add_lat", cyc, W + 1);
    check("add_done_tanh", add_done_t, 1);
    check("busy_at_done", busy_r, 0);
    e = exp_q.pop_front();
    check("acc_relu", acc_dbg_r, e);
    check("acc_tanh", acc_dbg_t, e);
    check("vout_hold", vout_r, to_w(m_vr));
  endtask

  task automatic do_bias(input logic [W-1:0] bv);
    int cyc;
    logic [W-1:0] e;
    m_acc = clampi(m_acc + sx(bv), MINV, MAXV);
    m_vr  = (m_acc < 0) ? 0 : m_acc;
    m_vt  = clampi(m_acc, -ONEV, ONEV);
    exp_q.push_back(to_w(m_acc));
    exp_q.push_back(to_w(m_vr));
    exp_q.push_back(to_w(m_vt));
    bias_in = bv; bias_start = 1'b1;
    @(negedge clk);
    bias_start = 1'b0;
    cyc = 0;
    while (!act_done_r && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("act_lat", cyc, 2);
    check("act_done_tanh", act_done_t, 1);
    check("busy_at_act", busy_r, 0);
    e = exp_q.pop_front(); check("bias_acc", acc_dbg_r, e);
    e = exp_q.pop_front(); check("vout_relu", vout_r, e);
    e = exp_q.pop_front(); check("vout_tanh", vout_t, e);
  endtask

  task automatic mac_solo(input logic [W-1:0] a, input logic [W-1:0] b, input logic mux);
    do_mac(a, b, mux, 1'b0, 1'b0);
    @(negedge clk);
    check("add_pulse_width", add_done_r, 0);
  endtask

  task automatic bias_solo(input logic [W-1:0] bv);
    do_bias(bv);
    @(negedge clk);
    check("act_pulse_width", act_done_r, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    m_acc = 0; m_vr = 0; m_vt = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p0;
    rst = 1'b1; mul_start = 1'b0; bias_start = 1'b0; acc_mux = 1'b0;
    a_in = '0; b_in = '0; bias_in = '0;
    repeat (3) @(negedge clk);
    check("rst_acc", acc_dbg_r, 0);
    check("rst_vout_relu", vout_r, 0);
    check("rst_vout_tanh", vout_t, 0);
    check("rst_busy", busy_r, 0);
    check("rst_proto", proto_r, 0);
    check("rst_add_done", add_done_r, 0);
    check("rst_act_done", act_done_r, 0);
    check("rst_state", state_r, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic MAC and accumulate.
    mac_solo(8'h20, 8'h30, 1'b0); check("plan_basic0", acc_dbg_r, 8'h30);
    mac_solo(8'h20, 8'hF0, 1'b1); check("plan_basic1", acc_dbg_r, 8'h20);
    // Signs, floor, saturation.
    mac_solo(8'h7F, 8'h7F, 1'b0); check("plan_sat_pos", acc_dbg_r, 8'h7F);
    mac_solo(8'h80, 8'h7F, 1'b0); check("plan_sat_neg", acc_dbg_r, 8'h80);
    mac_solo(8'hFF, 8'h01, 1'b0); check("plan_floor", acc_dbg_r, 8'hFF);
    // Bias + activation.
    mac_solo(8'h20, 8'h20, 1'b0);
    bias_solo(8'hC0);
    check("plan_relu", vout_r, 8'h00);
    check("plan_tanh", vout_t, 8'hE0);
    mac_solo(8'h20, 8'h60, 1'b0);
    bias_solo(8'h10);
    check("plan_tanh_clip", vout_t, 8'h20);
    check("plan_relu_pos", vout_r, 8'h70);
    check("no_proto_yet", proto_r, 0);

    // Back-to-back: four MACs and a bias with no idle gaps.
    p0 = add_pulses;
    do_mac(8'h30, 8'h10, 1'b0, 1'b0, 1'b0);
    do_mac(8'hE8, 8'h20, 1'b1, 1'b0, 1'b0);
    do_mac(8'h40, 8'h28, 1'b1, 1'b0, 1'b0);
    do_mac(8'h18, 8'hC8, 1'b1, 1'b0, 1'b0);
    do_bias(8'h08);
    @(negedge clk);
    check("b2b_pulses", add_pulses - p0, 4);

    // Randomized command stream.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if (i % 6 == 5) do_bias(ra);
      else do_mac(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    check("rand_no_proto", proto_r, 0);

    // Protocol error: command during MUL is ignored.
    mac_solo(8'h20, 8'h30, 1'b0);
    do_mac(8'h20, 8'h30, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("proto_mul_relu", proto_r, 1);
    check("proto_mul_tanh", proto_t, 1);
    check("proto_mul_acc", acc_dbg_r, 8'h30);

    // Protocol error: both commands together, MAC wins.
    do_reset(2);
    check("proto_cleared", proto_r, 0);
    p0 = act_pulses;
    do_mac(8'h20, 8'h40, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("both_no_act", act_pulses - p0, 0);
    check("both_idle", state_r, 0);
    check("both_proto", proto_r, 1);
    check("both_acc", acc_dbg_r, 8'h40);

    // Reset mid-MUL aborts with no done pulse.
    mac_solo(8'h20, 8'h60, 1'b0);
    bias_solo(8'h10);
    a_in = 8'h20; b_in = 8'h30; acc_mux = 1'b0; mul_start = 1'b1;
    @(negedge clk);
    mul_start = 1'b0;
    repeat (2) @(negedge clk);
    p0 = add_pulses;
    do_reset(2);
    repeat (12) @(negedge clk);
    check("midrst_no_done", add_pulses - p0, 0);
    check("midrst_acc", acc_dbg_r, 0);
    check("midrst_vout", vout_r, 0);
    check("midrst_busy", busy_r, 0);
    check("midrst_proto", proto_r, 0);
    mac_solo(8'h20, 8'h30, 1'b1);
    check("midrst_accum_from_zero", acc_dbg_r, 8'h30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
